// File: rtl/program_sequencer.sv
// Program sequencer: stores miniCPU instruction words and replays them into the datapath
// over an issue/ready/done handshake with single-step, abort and per-instruction watchdog.
module program_sequencer #(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned AW      = 4,
  parameter int unsigned IW      = 18,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_valid,
  input  logic [IW-1:0] load_instr,
  input  logic          prog_clear,
  input  logic          start,
  input  logic          step_mode,
  input  logic          step,
  input  logic          abort,
  output logic          issue_valid,
  output logic [IW-1:0] issue_instr,
  input  logic          issue_ready,
  input  logic          exec_done,
  output logic [AW-1:0] pc,
  output logic [AW:0]   prog_count,
  output logic          running,
  output logic          paused,
  output logic          run_done,
  output logic          load_reject,
  output logic          timeout_err
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StPause} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [AW:0]   count_q, count_d;
  logic [CW-1:0] wdog_q, wdog_d;
  logic          run_done_q, run_done_d;
  logic          reject_q, reject_d;
  logic          timeout_q, timeout_d;
  logic          mem_we;
  logic          last_slot;
  logic          full;

  logic [IW-1:0] mem [DEPTH];

  assign last_slot = ({1'b0, pc_q} == (count_q - (AW+1)'(1)));
  assign full      = (count_q == (AW+1)'(DEPTH));

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    count_d    = count_q;
    timeout_d  = timeout_q;
    run_done_d = 1'b0;
    reject_d   = 1'b0;
    mem_we     = 1'b0;
    // Counter runs only while waiting, so it is zero on every entry to StWait.
    wdog_d     = (state_q == StWait) ? wdog_q + CW'(1) : '0;

    unique case (state_q)
      StIdle: begin
        if (prog_clear) begin
          count_d = '0;
        end else if (load_valid) begin
          if (full) begin
            reject_d = 1'b1;
          end else begin
            mem_we  = 1'b1;
            count_d = count_q + (AW+1)'(1);
          end
        end
        if (start && (count_q != '0)) begin
          pc_d      = '0;
          timeout_d = 1'b0;
          state_d   = StIssue;
        end
      end
      StIssue: begin
        if (abort) begin
          state_d = StIdle;
        end else if (issue_ready) begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (abort) begin
          state_d = StIdle;
        end else if (exec_done) begin
          if (last_slot) begin
            state_d    = StIdle;
            run_done_d = 1'b1;
            pc_d       = '0;
          end else begin
            pc_d    = pc_q + AW'(1);
            state_d = step_mode ? StPause : StIssue;
          end
        end else if (wdog_q == CW'(TIMEOUT - 1)) begin
          timeout_d = 1'b1;
          state_d   = StIdle;
        end
      end
      StPause: begin
        if (abort) begin
          state_d = StIdle;
        end else if (step) begin
          state_d = StIssue;
        end
      end
      default: state_d = StIdle;
    endcase

    if ((state_q != StIdle) && load_valid) begin
      reject_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      pc_q       <= '0;
      count_q    <= '0;
      wdog_q     <= '0;
      run_done_q <= 1'b0;
      reject_q   <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      count_q    <= count_d;
      wdog_q     <= wdog_d;
      run_done_q <= run_done_d;
      reject_q   <= reject_d;
      timeout_q  <= timeout_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[count_q[AW-1:0]] <= load_instr;
    end
  end

  assign issue_valid = (state_q == StIssue);
  assign issue_instr = mem[pc_q];
  assign pc          = pc_q;
  assign prog_count  = count_q;
  assign running     = (state_q != StIdle);
  assign paused      = (state_q == StPause);
  assign run_done    = run_done_q;
  assign load_reject = reject_q;
  assign timeout_err = timeout_q;

endmodule

// File: tb/tb_program_sequencer.sv
// Self-checking bench for program_sequencer: a model program memory feeds a scoreboard of
// expected (pc, instruction) issues that is popped as the DUT offers each instruction.
module tb_program_sequencer;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int IW    = 18;
  localparam int TO    = 8;

  logic          clk = 1'b0;
  logic          reset, load_valid, prog_clear, start, step_mode, step, abort;
  logic [IW-1:0] load_instr;
  logic          issue_valid, issue_ready, exec_done;
  logic [IW-1:0] issue_instr;
  logic [AW-1:0] pc;
  logic [AW:0]   prog_count;
  logic          running, paused, run_done, load_reject, timeout_err;

  always #5 clk = ~clk;

  program_sequencer #(.DEPTH(DEPTH), .AW(AW), .IW(IW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_instr(load_instr),
    .prog_clear(prog_clear), .start(start), .step_mode(step_mode), .step(step),
    .abort(abort), .issue_valid(issue_valid), .issue_instr(issue_instr),
    .issue_ready(issue_ready), .exec_done(exec_done), .pc(pc), .prog_count(prog_count),
    .running(running), .paused(paused), .run_done(run_done), .load_reject(load_reject),
    .timeout_err(timeout_err)
  );

  typedef struct {
    logic [AW-1:0] pc;
    logic [IW-1:0] instr;
  } exp_t;

  exp_t          exp_q[$];
  logic [IW-1:0] model_mem [DEPTH];
  int            model_cnt = 0;
  int            checks = 0;
  int            errors = 0;
  int            rd_cnt = 0;
  int            rej_cnt = 0;

  always @(posedge clk) begin
    if (run_done) rd_cnt++;
    if (load_reject) rej_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at 200000 required finish");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [IW-1:0] w);
    load_valid = 1'b1;
    load_instr = w;
    tick();
    load_valid = 1'b0;
    if (model_cnt < DEPTH) begin
      model_mem[model_cnt] = w;
      model_cnt++;
    end
  endtask

  task automatic clear_prog;
    prog_clear = 1'b1;
    tick();
    prog_clear = 1'b0;
    model_cnt = 0;
    exp_q.delete();
  endtask

  task automatic push_run;
    exp_t e;
    for (int i = 0; i < model_cnt; i++) begin
      e.pc    = AW'(i);
      e.instr = model_mem[i];
      exp_q.push_back(e);
    end
  endtask

  task automatic do_start;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Waits for an offered instruction, checks it against the scoreboard, accepts it.
  task automatic accept_one(output bit ok);
    exp_t e;
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (issue_valid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL issue_wait: issue_valid=0 required 1 within 20 cycles");
      return;
    end
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: got issue %h with no expected entry", issue_instr);
      return;
    end
    e = exp_q.pop_front();
    checks++;
    if (issue_instr !== e.instr) begin
      errors++;
      $display("FAIL issue_instr: got %h required %h", issue_instr, e.instr);
    end
    checks++;
    if (pc !== e.pc) begin
      errors++;
      $display("FAIL issue_pc: got %0d required %0d", pc, e.pc);
    end
    tick();
    tick();
    issue_ready = 1'b1;
    tick();
    issue_ready = 1'b0;
    checks++;
    if (issue_valid !== 1'b0 || running !== 1'b1) begin
      errors++;
      $display("FAIL wait_entry: issue_valid=%b running=%b required 0 1", issue_valid, running);
    end
  endtask

  task automatic finish_one(input bit last, input bit stepping);
    exec_done = 1'b1;
    tick();
    exec_done = 1'b0;
    checks++;
    if (last) begin
      if (run_done !== 1'b1 || running !== 1'b0 || pc !== '0) begin
        errors++;
        $display("FAIL run_end: run_done=%b running=%b pc=%0d required 1 0 0",
                 run_done, running, pc);
      end
    end else if (stepping) begin
      if (paused !== 1'b1 || issue_valid !== 1'b0) begin
        errors++;
        $display("FAIL pause_entry: paused=%b issue_valid=%b required 1 0", paused, issue_valid);
      end
    end else if (issue_valid !== 1'b1) begin
      errors++;
      $display("FAIL next_issue_latency: issue_valid=%b required 1", issue_valid);
    end
  endtask

  task automatic run_program(input int n, input bit stepping);
    bit ok;
    for (int i = 0; i < n; i++) begin
      accept_one(ok);
      if (!ok) return;
      finish_one(i == n - 1, stepping);
      if (stepping && i < n - 1) begin
        step_mode = 1'b0;
        repeat (3) tick();
        checks++;
        if (paused !== 1'b1 || issue_valid !== 1'b0) begin
          errors++;
          $display("FAIL pause_hold: paused=%b issue_valid=%b required 1 0", paused, issue_valid);
        end
        step = 1'b1;
        tick();
        step = 1'b0;
        step_mode = 1'b1;
        checks++;
        if (issue_valid !== 1'b1 || paused !== 1'b0) begin
          errors++;
          $display("FAIL step_release: issue_valid=%b paused=%b required 1 0",
                   issue_valid, paused);
        end
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checks++;
    if ({issue_valid, running, paused, run_done, load_reject, timeout_err} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b required 000000",
               {issue_valid, running, paused, run_done, load_reject, timeout_err});
    end
    checks++;
    if (pc !== '0 || prog_count !== '0) begin
      errors++;
      $display("FAIL reset_counts: pc=%0d prog_count=%0d required 0 0", pc, prog_count);
    end
    do_start();
    checks++;
    if (running !== 1'b0 || issue_valid !== 1'b0) begin
      errors++;
      $display("FAIL start_empty: running=%b issue_valid=%b required 0 0", running, issue_valid);
    end
  endtask

  task automatic test_basic;
    int rd0;
    clear_prog();
    load_word(18'h00805);
    load_word({3'd1, 4'd2, 4'd1, 7'd3});
    load_word({3'd6, 4'd0, 4'd2, 7'd0});
    checks++;
    if (prog_count !== 5'd3) begin
      errors++;
      $display("FAIL basic_count: prog_count=%0d required 3", prog_count);
    end
    rd0 = rd_cnt;
    push_run();
    do_start();
    checks++;
    if (issue_valid !== 1'b1) begin
      errors++;
      $display("FAIL start_latency: issue_valid=%b required 1", issue_valid);
    end
    run_program(3, 1'b0);
    tick();
    checks++;
    if (rd_cnt - rd0 !== 1 || prog_count !== 5'd3 || exp_q.size() !== 0) begin
      errors++;
      $display("FAIL basic_end: run_done pulses=%0d prog_count=%0d left=%0d required 1 3 0",
               rd_cnt - rd0, prog_count, exp_q.size());
    end
  endtask

  task automatic test_full;
    int rej0;
    clear_prog();
    rej0 = rej_cnt;
    for (int i = 0; i < DEPTH + 1; i++) begin
      load_word(IW'(i * 12345 + 7));
    end
    checks++;
    if (load_reject !== 1'b1) begin
      errors++;
      $display("FAIL full_reject: load_reject=%b required 1", load_reject);
    end
    tick();
    checks++;
    if (rej_cnt - rej0 !== 1 || prog_count !== 5'd16) begin
      errors++;
      $display("FAIL full_count: rejects=%0d prog_count=%0d required 1 16",
               rej_cnt - rej0, prog_count);
    end
    push_run();
    do_start();
    run_program(DEPTH, 1'b0);
  endtask

  task automatic test_step;
    clear_prog();
    load_word(18'h2A5A5);
    load_word(18'h15A5A);
    step_mode = 1'b1;
    push_run();
    do_start();
    run_program(2, 1'b1);
    step_mode = 1'b0;
  endtask

  task automatic test_abort;
    logic [IW-1:0] held;
    int            rd0;
    bit            ok;
    exp_t          e;
    clear_prog();
    load_word(18'h3C3C3);
    load_word(18'h0F0F0);
    push_run();
    rd0 = rd_cnt;
    do_start();
    e = exp_q.pop_front();
    checks++;
    if (issue_valid !== 1'b1 || issue_instr !== e.instr) begin
      errors++;
      $display("FAIL abort_first: issue_valid=%b instr=%h required 1 %h",
               issue_valid, issue_instr, e.instr);
    end
    held = issue_instr;
    load_valid = 1'b1;
    prog_clear = 1'b1;
    load_instr = 18'h11111;
    tick();
    load_valid = 1'b0;
    prog_clear = 1'b0;
    checks++;
    if (load_reject !== 1'b1 || prog_count !== 5'd2) begin
      errors++;
      $display("FAIL run_load: load_reject=%b prog_count=%0d required 1 2",
               load_reject, prog_count);
    end
    ok = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (issue_valid !== 1'b1 || issue_instr !== held) ok = 1'b0;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL hold_stable: issue_valid=%b instr=%h required 1 %h",
               issue_valid, issue_instr, held);
    end
    abort = 1'b1;
    issue_ready = 1'b1;
    tick();
    abort = 1'b0;
    issue_ready = 1'b0;
    checks++;
    if (running !== 1'b0 || issue_valid !== 1'b0 || prog_count !== 5'd2 || run_done !== 1'b0) begin
      errors++;
      $display("FAIL abort_state: running=%b valid=%b count=%0d done=%b required 0 0 2 0",
               running, issue_valid, prog_count, run_done);
    end
    tick();
    checks++;
    if (rd_cnt !== rd0) begin
      errors++;
      $display("FAIL abort_no_done: run_done pulses=%0d required 0", rd_cnt - rd0);
    end
    exp_q.delete();
  endtask

  task automatic test_timeout;
    bit ok;
    int n;
    clear_prog();
    load_word(18'h12345);
    load_word(18'h23456);
    push_run();
    do_start();
    accept_one(ok);
    n = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (timeout_err) begin
        n = k;
        break;
      end
    end
    checks++;
    if (n !== TO) begin
      errors++;
      $display("FAIL timeout_delay: cycles=%0d required %0d", n, TO);
    end
    checks++;
    if (running !== 1'b0 || pc !== '0) begin
      errors++;
      $display("FAIL timeout_state: running=%b pc=%0d required 0 0", running, pc);
    end
    do_start();
    checks++;
    if (timeout_err !== 1'b0 || issue_valid !== 1'b1) begin
      errors++;
      $display("FAIL timeout_clear: timeout_err=%b issue_valid=%b required 0 1",
               timeout_err, issue_valid);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_reset_midrun;
    bit ok;
    clear_prog();
    load_word(18'h01010);
    load_word(18'h02020);
    load_word(18'h03030);
    push_run();
    do_start();
    accept_one(ok);
    finish_one(1'b0, 1'b0);
    accept_one(ok);
    finish_one(1'b0, 1'b0);
    accept_one(ok);
    checks++;
    if (pc !== 4'd2 || running !== 1'b1) begin
      errors++;
      $display("FAIL midrun_pc: pc=%0d running=%b required 2 1", pc, running);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (running !== 1'b0 || pc !== '0 || prog_count !== '0 || issue_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrun_reset: running=%b pc=%0d count=%0d valid=%b required 0 0 0 0",
               running, pc, prog_count, issue_valid);
    end
    model_cnt = 0;
    exp_q.delete();
    do_start();
    checks++;
    if (running !== 1'b0) begin
      errors++;
      $display("FAIL midrun_start: running=%b required 0", running);
    end
  endtask

  initial begin
    reset = 1'b1;
    load_valid = 1'b0;
    load_instr = '0;
    prog_clear = 1'b0;
    start = 1'b0;
    step_mode = 1'b0;
    step = 1'b0;
    abort = 1'b0;
    issue_ready = 1'b0;
    exec_done = 1'b0;
    test_reset();
    test_basic();
    test_full();
    test_step();
    test_abort();
    test_timeout();
    test_reset_midrun();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
